// File: rtl/wb_stage_if.sv
// Purpose : bundles the lane-side result inputs and the register-file / ROB write
//           ports of the writeback stage, together with the flush strobe.
// Ports   : flush, in_valid/in_data/in_dest/in_rob, lane_ready (lane side);
//           rf_we/rf_waddr/rf_wdata, rob_done/rob_done_idx, overflow (commit side).
//           master = execution side / driver, slave = wb_stage.
interface wb_stage_if #(
  parameter int LANES = 8,
  parameter int PORTS = 4
);
  logic                    flush;
  logic [LANES-1:0]        in_valid;
  logic [LANES-1:0][63:0]  in_data;
  logic [LANES-1:0][6:0]   in_dest;
  logic [LANES-1:0][7:0]   in_rob;
  logic [LANES-1:0]        lane_ready;
  logic [PORTS-1:0]        rf_we;
  logic [PORTS-1:0][6:0]   rf_waddr;
  logic [PORTS-1:0][63:0]  rf_wdata;
  logic [PORTS-1:0]        rob_done;
  logic [PORTS-1:0][7:0]   rob_done_idx;
  logic                    overflow;

  modport master (
    output flush, in_valid, in_data, in_dest, in_rob,
    input  lane_ready, rf_we, rf_waddr, rf_wdata, rob_done, rob_done_idx, overflow
  );

  modport slave (
    input  flush, in_valid, in_data, in_dest, in_rob,
    output lane_ready, rf_we, rf_waddr, rf_wdata, rob_done, rob_done_idx, overflow
  );
endinterface

// File: rtl/wb_stage.sv
// Purpose : buffers up to LANES execution results per cycle in per-lane FIFOs and
//           round-robin drains them onto PORTS register-file / ROB completion ports.
// Latency : 2 cycles input to rf_we (1 cycle for a granted bypass when WB_BYPASS_EN is defined).
// Backpr. : lane_ready[i] = registered count < DEPTH; a result on a non-ready lane is
//           dropped and sets the sticky overflow flag.
// Ports   : clk, rst (async active-high), bus (wb_stage_if.slave: flush, in_*, lane_ready,
//           rf_*, rob_done*, overflow).
// Option  : WB_BYPASS_EN - an empty lane's incoming result may be granted in the same cycle.
module wb_stage #(
  parameter int LANES = 8,
  parameter int PORTS = 4,
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  wb_stage_if.slave bus
);

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count [LANES];
  logic [PW-1:0] head  [LANES];
  logic [PW-1:0] tail  [LANES];
  logic [63:0]   mem_data [LANES][DEPTH];
  logic [6:0]    mem_dest [LANES][DEPTH];
  logic [7:0]    mem_rob  [LANES][DEPTH];
  logic [LW-1:0] rr_ptr;

  logic [LANES-1:0] rdy, eligible, grant, push, pop;
  logic [63:0]      hd_data [LANES];
  logic [6:0]       hd_dest [LANES];
  logic [7:0]       hd_rob  [LANES];

  logic [LW-1:0]    port_lane [PORTS];
  logic [PORTS-1:0] port_act;
  logic [LW-1:0]    last_lane;

  logic [PORTS-1:0]       we_q;
  logic [PORTS-1:0][6:0]  waddr_q;
  logic [PORTS-1:0][63:0] wdata_q;
  logic [PORTS-1:0][7:0]  idx_q;
  logic                   ovf_q;

  // Per-lane status, head selection and push/pop qualification.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rdy[i]      = (count[i] < CW'(DEPTH));
      eligible[i] = (count[i] != '0);
      hd_data[i]  = mem_data[i][head[i]];
      hd_dest[i]  = mem_dest[i][head[i]];
      hd_rob[i]   = mem_rob[i][head[i]];
`ifdef WB_BYPASS_EN
      // An empty lane offers its incoming result straight to the arbiter.
      if (count[i] == '0) begin
        eligible[i] = bus.in_valid[i];
        hd_data[i]  = bus.in_data[i];
        hd_dest[i]  = bus.in_dest[i];
        hd_rob[i]   = bus.in_rob[i];
      end
`endif
      pop[i]  = grant[i] && (count[i] != '0);
      // A granted bypass result leaves through the output register, not the FIFO.
      push[i] = bus.in_valid[i] && rdy[i] && !(grant[i] && (count[i] == '0));
    end
  end

  // Round-robin scan from rr_ptr; grant k lands on port k.
  always_comb begin
    int            ng;
    logic [LW-1:0] lane;
    grant     = '0;
    port_act  = '0;
    last_lane = rr_ptr;
    ng        = 0;
    lane      = '0;
    for (int k = 0; k < PORTS; k++) port_lane[k] = '0;
    for (int j = 0; j < LANES; j++) begin
      lane = LW'((int'(rr_ptr) + j) % LANES);
      if (eligible[lane] && (ng < PORTS)) begin
        grant[lane]   = 1'b1;
        port_lane[ng] = lane;
        port_act[ng]  = 1'b1;
        last_lane     = lane;
        ng++;
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push[i] && !bus.flush) begin
        mem_data[i][tail[i]] <= bus.in_data[i];
        mem_dest[i][tail[i]] <= bus.in_dest[i];
        mem_rob[i][tail[i]]  <= bus.in_rob[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
      rr_ptr  <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.flush) begin
      // Flush beats push, pop and grant; data/index fields keep their last values.
      for (int i = 0; i < LANES; i++) begin
        count[i] <= '0;
        head[i]  <= '0;
        tail[i]  <= '0;
      end
      rr_ptr <= '0;
      we_q   <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push[i]) tail[i] <= tail[i] + PW'(1);
        if (pop[i])  head[i] <= head[i] + PW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
      end
      if (|(bus.in_valid & ~rdy)) ovf_q <= 1'b1;
      for (int k = 0; k < PORTS; k++) begin
        we_q[k] <= port_act[k];
        if (port_act[k]) begin
          waddr_q[k] <= hd_dest[port_lane[k]];
          wdata_q[k] <= hd_data[port_lane[k]];
          idx_q[k]   <= hd_rob[port_lane[k]];
        end
      end
      if (|grant) rr_ptr <= (last_lane == LW'(LANES - 1)) ? '0 : last_lane + LW'(1);
    end
  end

  assign bus.lane_ready   = rdy;
  assign bus.rf_we        = we_q;
  assign bus.rob_done     = we_q;
  assign bus.rf_waddr     = waddr_q;
  assign bus.rf_wdata     = wdata_q;
  assign bus.rob_done_idx = idx_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_wb_stage.sv
// Purpose : directed bench for wb_stage (default build, LANES=8 PORTS=4 DEPTH=2).
// Timing  : inputs are driven and outputs sampled on the falling clock edge.
// Ports   : drives the wb_stage_if master side; clk/rst are plain signals.
module tb_wb_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr();
    bus.in_valid = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic put(input int l, input logic [63:0] d, input logic [6:0] dst, input logic [7:0] rb);
    bus.in_valid[l] = 1'b1;
    bus.in_data[l]  = d;
    bus.in_dest[l]  = dst;
    bus.in_rob[l]   = rb;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clr();
    bus.in_data = '0;
    bus.in_dest = '0;
    bus.in_rob  = '0;

    // Reset state
    step();
    chk("rst_we",    64'(bus.rf_we), 0);
    chk("rst_done",  64'(bus.rob_done), 0);
    chk("rst_ovf",   64'(bus.overflow), 0);
    chk("rst_waddr", 64'(bus.rf_waddr), 0);
    chk("rst_wdata", 64'(|bus.rf_wdata), 0);
    chk("rst_idx",   64'(bus.rob_done_idx), 0);
    rst = 1'b0;
    step();
    chk("rst_rdy", 64'(bus.lane_ready), 64'hFF);

    // Single result on lane 5: visible two edges later on port 0
    put(5, 64'h1234, 7'd9, 8'd20);
    step();
    clr();
    chk("single_early_we", 64'(bus.rf_we), 0);
    step();
    chk("single_we",    64'(bus.rf_we), 64'h1);
    chk("single_done",  64'(bus.rob_done), 64'h1);
    chk("single_waddr", 64'(bus.rf_waddr[0]), 9);
    chk("single_wdata", bus.rf_wdata[0], 64'h1234);
    chk("single_idx",   64'(bus.rob_done_idx[0]), 20);
    step();
    chk("single_idle_we",   64'(bus.rf_we), 0);
    chk("single_hold_addr", 64'(bus.rf_waddr[0]), 9);

    // Flush alone: returns rr_ptr to 0
    bus.flush = 1'b1;
    step();
    clr();
    chk("flush0_we", 64'(bus.rf_we), 0);

    // Contention: all 8 lanes, rr_ptr=0 -> lanes 0-3 then 4-7
    for (int l = 0; l < 8; l++) put(l, 64'hA000 + 64'(l), 7'(16 + l), 8'(40 + l));
    step();
    clr();
    chk("cont_rdy",  64'(bus.lane_ready), 64'hFF);
    chk("cont_we0",  64'(bus.rf_we), 0);
    step();
    chk("cont_weA",  64'(bus.rf_we), 64'hF);
    for (int k = 0; k < 4; k++) begin
      chk("cont_idxA",   64'(bus.rob_done_idx[k]), 64'(40 + k));
      chk("cont_waddrA", 64'(bus.rf_waddr[k]), 64'(16 + k));
      chk("cont_wdataA", bus.rf_wdata[k], 64'hA000 + 64'(k));
    end
    step();
    chk("cont_weB", 64'(bus.rf_we), 64'hF);
    for (int k = 0; k < 4; k++) begin
      chk("cont_idxB", 64'(bus.rob_done_idx[k]), 64'(44 + k));
      chk("cont_waddrB", 64'(bus.rf_waddr[k]), 64'(20 + k));
    end
    step();
    chk("cont_we_end", 64'(bus.rf_we), 0);

    // Wrap: 10 back-to-back results on lane 0
    for (int k = 0; k < 10; k++) begin
      put(0, 64'hB00 + 64'(k), 7'd5, 8'(100 + k));
      step();
      chk("wrap_rdy", 64'(bus.lane_ready[0]), 1);
      if (k > 0) begin
        chk("wrap_we",    64'(bus.rf_we), 64'h1);
        chk("wrap_idx",   64'(bus.rob_done_idx[0]), 64'(99 + k));
        chk("wrap_wdata", bus.rf_wdata[0], 64'hB00 + 64'(k - 1));
      end
    end
    clr();
    step();
    chk("wrap_last_we",  64'(bus.rf_we), 64'h1);
    chk("wrap_last_idx", 64'(bus.rob_done_idx[0]), 109);
    step();
    chk("wrap_we_end", 64'(bus.rf_we), 0);
    chk("wrap_ovf",    64'(bus.overflow), 0);

    // Flush with 6 buffered entries and a same-cycle push on lane 1
    for (int l = 0; l < 6; l++) put(l, 64'hC00 + 64'(l), 7'(30 + l), 8'(120 + l));
    step();
    clr();
    bus.flush = 1'b1;
    put(1, 64'hC99, 7'd31, 8'd130);
    step();
    clr();
    chk("flush_we",  64'(bus.rf_we), 0);
    chk("flush_ovf", 64'(bus.overflow), 0);
    chk("flush_rdy", 64'(bus.lane_ready), 64'hFF);
    step();
    chk("flush_we1", 64'(bus.rf_we), 0);
    step();
    chk("flush_we2", 64'(bus.rf_we), 0);
    // rr_ptr back at 0: lanes 0,4,5,6 first, lane 7 next
    put(0, 64'hE0, 7'd50, 8'd140);
    for (int l = 4; l < 8; l++) put(l, 64'hE0 + 64'(l), 7'(50 + l), 8'(140 + l));
    step();
    clr();
    step();
    chk("rr0_we",   64'(bus.rf_we), 64'hF);
    chk("rr0_idx0", 64'(bus.rob_done_idx[0]), 140);
    chk("rr0_idx1", 64'(bus.rob_done_idx[1]), 144);
    chk("rr0_idx3", 64'(bus.rob_done_idx[3]), 146);
    step();
    chk("rr0_we2",  64'(bus.rf_we), 64'h1);
    chk("rr0_idx7", 64'(bus.rob_done_idx[0]), 147);
    step();
    chk("rr0_we_end", 64'(bus.rf_we), 0);

    // Backpressure on lane 2 (rr_ptr=0 here)
    put(2, 64'hD3C, 7'd2, 8'd60);
    step();
    clr();
    put(2, 64'hD50, 7'd2, 8'd80);
    for (int l = 3; l < 7; l++) put(l, 64'hD00 + 64'(l), 7'(60 + l), 8'(60 + l));
    step();
    clr();
    chk("bp_pre_we",  64'(bus.rf_we), 64'h1);
    chk("bp_pre_idx", 64'(bus.rob_done_idx[0]), 60);
    chk("bp_rdy1",    64'(bus.lane_ready), 64'hFF);
    put(2, 64'hD51, 7'd2, 8'd81);
    step();
    clr();
    chk("bp_busy_we",   64'(bus.rf_we), 64'hF);
    chk("bp_busy_idx0", 64'(bus.rob_done_idx[0]), 63);
    chk("bp_busy_idx3", 64'(bus.rob_done_idx[3]), 66);
    chk("bp_rdy_full",  64'(bus.lane_ready), 64'hFB);
    chk("bp_ovf0",      64'(bus.overflow), 0);
    put(2, 64'hD52, 7'd2, 8'd82);
    step();
    clr();
    chk("bp_ovf1",   64'(bus.overflow), 1);
    chk("bp_we80",   64'(bus.rf_we), 64'h1);
    chk("bp_idx80",  64'(bus.rob_done_idx[0]), 80);
    chk("bp_data80", bus.rf_wdata[0], 64'hD50);
    step();
    chk("bp_we81",  64'(bus.rf_we), 64'h1);
    chk("bp_idx81", 64'(bus.rob_done_idx[0]), 81);
    chk("bp_ovf2",  64'(bus.overflow), 1);
    step();
    chk("bp_no82",  64'(bus.rf_we), 0);
    step();
    chk("bp_no82b", 64'(bus.rf_we), 0);
    chk("bp_ovf3",  64'(bus.overflow), 1);

    // Reset mid-burst with lanes 0-2 holding entries
    for (int l = 0; l < 3; l++) put(l, 64'hF00 + 64'(l), 7'(70 + l), 8'(150 + l));
    step();
    for (int l = 0; l < 3; l++) put(l, 64'hF10 + 64'(l), 7'(80 + l), 8'(160 + l));
    step();
    clr();
    chk("mid_we",   64'(bus.rf_we), 64'h7);
    chk("mid_idx0", 64'(bus.rob_done_idx[0]), 150);
    rst = 1'b1;
    #1;
    chk("mid_rst_we",    64'(bus.rf_we), 0);
    chk("mid_rst_ovf",   64'(bus.overflow), 0);
    chk("mid_rst_waddr", 64'(bus.rf_waddr), 0);
    step();
    rst = 1'b0;
    chk("mid_rdy", 64'(bus.lane_ready), 64'hFF);
    step();
    chk("mid_stale1", 64'(bus.rf_we), 0);
    step();
    chk("mid_stale2", 64'(bus.rf_we), 0);
    chk("mid_ovf",    64'(bus.overflow), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the execution stage.
- Accepts up to LANES results per cycle and buffers them in a per-lane FIFO.
- Round-robin arbitrates the buffered results onto PORTS register-file write ports and the matching ROB completion ports.
- Exists because the execution stage can complete more results per cycle than the register file has write ports.

Parameters:
LANES, 8, number of result lanes from the execution stage
PORTS, 4, register-file write / ROB completion ports per cycle
DEPTH, 2, entries per lane FIFO (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous flush of all buffered results
in_valid  input  LANES  result valid per lane
in_data  input  64 x LANES  result data
in_dest  input  7 x LANES  destination physical register
in_rob  input  8 x LANES  ROB index
lane_ready  output  LANES  lane FIFO can accept this cycle
rf_we  output  PORTS  register-file write enable
rf_waddr  output  7 x PORTS  write address
rf_wdata  output  64 x PORTS  write data
rob_done  output  PORTS  ROB completion valid (mirrors rf_we)
rob_done_idx  output  8 x PORTS  completed ROB index
overflow  output  1  sticky: a result arrived on a non-ready lane

Behaviour:
- Reset: clock is clk; reset is asynchronous and active-high (rst).
  - All FIFOs empty, rr_ptr=0.
  - rf_we=0, rob_done=0, overflow=0.
  - rf_waddr, rf_wdata and rob_done_idx = 0.
  - lane_ready = all ones once rst deasserts.
  - Reset mid-operation discards every buffered and in-flight result.
- Push:
  - lane_ready[i] = (count[i] < DEPTH), based on registered count only.
  - A full lane that pops in the same cycle still reports not-ready. No same-cycle push-through on a full lane.
  - in_valid[i] && lane_ready[i] writes the entry at the tail on the clk edge.
- Overflow:
  - in_valid[i] && !lane_ready[i] drops the result and sets overflow.
  - overflow is cleared only by rst.
- Arbitration (combinational, per cycle):
  - Scan lanes rr_ptr, rr_ptr+1, ... modulo LANES.
  - Grant the first min(PORTS, nonempty) lanes with count>0, at most one entry per lane per cycle.
  - Grant k goes to port k in scan order; ports above the grant count are idle.
- rr_ptr update:
  - After a cycle with >=1 grant: rr_ptr = (last granted lane + 1) mod LANES.
  - No grants: rr_ptr unchanged.
- Pop: every granted lane pops its head on the same edge.
- Outputs:
  - Registered. Granted head data/dest/rob are driven on rf_* / rob_done_* in the cycle after the grant.
  - rf_we[k] == rob_done[k] always.
  - Idle ports: we=0; data, address and index fields hold their previous values.
- Latency: result sampled at edge E0 → FIFO. Granted in the following cycle → visible on rf_we after edge E1. Minimum latency 2 cycles with no contention.
- Ordering: FIFO order within a lane. No ordering is guaranteed across lanes.
- Simultaneous push and pop on a non-full lane: both take effect and count is unchanged.
- Pointer wrap: head and tail pointers wrap modulo DEPTH. count is held separately (width clog2(DEPTH)+1) to distinguish full from empty.
- Flush:
  - On an edge with flush=1, all FIFOs are emptied and rr_ptr=0.
  - Output registers rf_we/rob_done are cleared to 0 on that edge.
  - Pushes in the same cycle are discarded and do not set overflow.
  - Flush has priority over push, pop and grant.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - A lane whose FIFO is empty and which presents in_valid is eligible for arbitration in the same cycle (the incoming result is a candidate).
  - If granted, the result goes directly to the output register and is not written to the FIFO. Latency is 1 cycle.
  - If not granted, it is pushed normally.
- Not defined: the behaviour above; every result passes through its FIFO.

Test Plan:
- Reset: assert rst mid-burst with 3 lanes holding entries → next cycle rf_we=0, overflow=0, lane_ready=8'hFF after release; no stale writes appear afterwards.
- Single result: lane 5, data 64'h1234, dest 7'd9, rob 8'd20 → 2 cycles later rf_we=4'b0001, rf_waddr[0]=9, rf_wdata[0]=64'h1234, rob_done_idx[0]=20. With WB_BYPASS_EN the same appears 1 cycle later.
- Contention: all 8 lanes valid in one cycle, rr_ptr=0 → cycle A grants lanes 0-3 on ports 0-3 and rr_ptr becomes 4; cycle B grants lanes 4-7; every rob index appears exactly once.
- Backpressure: DEPTH=2, lane 2 valid on 3 consecutive cycles with other lanes kept busy so lane 2 is not granted → third push sees lane_ready[2]=0, overflow rises to 1 and stays 1; exactly two lane-2 results are written, in order.
- Wrap: 10 sequential results on lane 0 at one per cycle → 10 writes in input order; FIFO pointers wrap several times; no overflow.
- Flush: 6 entries buffered, assert flush together with new in_valid on lane 1 → no rf_we in any following cycle for those results, overflow=0, rr_ptr=0 (next grant starts at lane 0).
